// File: rtl/wide_add_pkg.sv
// Shared types for the word-serial wide adder.
// Slice width and FSM state encoding.
package wide_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/wide_add_seq.sv
// Word-serial wide adder driving an external shared Cla_32.
// Optional subtract mode: define WIDE_ADD_SUB_EN.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int IDX_W  = $clog2(NWORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] in_a,
  input  logic [WORD_W*NWORDS-1:0] in_b,
  input  logic                     in_cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic [WORD_W-1:0]        cla_x,
  output logic [WORD_W-1:0]        cla_y,
  output logic                     cla_cin,
  input  logic [WORD_W-1:0]        cla_sum,
  input  logic                     cla_c32
);

  localparam int W = WORD_W * NWORDS;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     res_q;
  logic             seed;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] y_word;
  logic             run;

`ifdef WIDE_ADD_SUB_EN
  logic sub_q;
  assign seed = in_sub ? 1'b1 : in_cin;
`else
  assign seed = in_cin;
`endif

  always_comb begin
    a_word = a_q[WORD_W*idx +: WORD_W];
`ifdef WIDE_ADD_SUB_EN
    y_word = sub_q ? ~b_q[WORD_W*idx +: WORD_W]
                   : b_q[WORD_W*idx +: WORD_W];
`else
    y_word = b_q[WORD_W*idx +: WORD_W];
`endif
  end

  // Adder inputs are held at zero outside RUN.
  assign run       = (state == RUN);
  assign cla_x     = run ? a_word : '0;
  assign cla_y     = run ? y_word : '0;
  assign cla_cin   = run & carry_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = out_valid ? res_q : '0;
  assign out_cout  = out_valid & carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef WIDE_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= seed;
            idx     <= '0;
            state   <= RUN;
`ifdef WIDE_ADD_SUB_EN
            sub_q   <= in_sub;
`endif
          end
        end
        RUN: begin
          res_q[WORD_W*idx +: WORD_W] <= cla_sum;
          carry_q <= cla_c32;
          if (idx == LAST) state <= DONE;
          else idx <= idx + IDX_W'(1);
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq with a behavioural Cla_32 beside it.
// Vector table, scoreboard queue and hand-written corner sequences.
module tb_wide_add_seq;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic [31:0]   cla_x;
  logic [31:0]   cla_y;
  logic          cla_cin;
  logic [31:0]   cla_sum;
  logic          cla_c32;

  always #5 clk = ~clk;

  assign {cla_c32, cla_sum} = {1'b0, cla_x} + {1'b0, cla_y} + 33'(cla_cin);

  wide_add_seq #(.NWORDS(NW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cin(in_cin),
`ifdef WIDE_ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout),
    .cla_x(cla_x),
    .cla_y(cla_y),
    .cla_cin(cla_cin),
    .cla_sum(cla_sum),
    .cla_c32(cla_c32)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t         sb[$];
  int           passed = 0;
  int           total  = 0;
  int           edges  = 0;
  int           delivered = 0;
  logic [W-1:0] pend_sum;
  logic         pend_cout;

  task automatic chk(string name, logic [W:0] act, logic [W:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: log handshakes at this negedge, then advance.
  task automatic cycle();
    exp_t e;
    if (in_valid && in_ready) begin
      e.sum  = pend_sum;
      e.cout = pend_cout;
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      delivered++;
      if (sb.size() == 0) begin
        chk("unexpected_result", '1, '0);
      end else begin
        e = sb.pop_front();
        chk("sum", {1'b0, out_sum}, {1'b0, e.sum});
        chk("cout", (W+1)'(out_cout), (W+1)'(e.cout));
      end
    end
    @(negedge clk);
    edges++;
  endtask

  function automatic logic [NW-1:0] slice_carries(vec_t v);
    logic [NW-1:0] cs;
    logic [32:0]   s;
    logic [31:0]   y;
    logic          c;
    c = v.sub ? 1'b1 : v.cin;
    for (int i = 0; i < NW; i++) begin
      cs[i] = c;
      y = v.b[32*i +: 32];
      if (v.sub) y = ~y;
      s = {1'b0, v.a[32*i +: 32]} + {1'b0, y} + 33'(c);
      c = s[32];
    end
    return cs;
  endfunction

  function automatic vec_t mk(logic [W-1:0] a, logic [W-1:0] b,
                              logic cin, logic sub,
                              logic [W-1:0] sum, logic cout);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.sum = sum; v.cout = cout;
    return v;
  endfunction

  task automatic do_op(vec_t v, int bp);
    logic [NW-1:0] cins;
    int            e0;
    int            k;
    bit            busy_ready;
    bit            stable;
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
    pend_sum = v.sum; pend_cout = v.cout;
    in_valid = 1'b1;
    out_ready = (bp == 0);
    e0 = edges;
    while (!in_ready && edges - e0 < 20) cycle();
    if (!in_ready) begin
      chk("accept_timeout", '0, '1);
      in_valid = 1'b0;
      return;
    end
    e0 = edges;
    cycle();
    in_valid = 1'b0;
    cins = '0;
    busy_ready = 1'b0;
    while (!out_valid && edges - e0 < 20) begin
      k = edges - e0 - 1;
      if (k >= 0 && k < NW) cins[k] = cla_cin;
      busy_ready |= in_ready;
      cycle();
    end
    chk("latency", (W+1)'(edges - e0), (W+1)'(NW + 1));
    chk("cla_cin_seq", (W+1)'(cins), (W+1)'(slice_carries(v)));
    chk("busy_in_ready", (W+1)'(busy_ready), '0);
    if (bp > 0) begin
      stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
        stable &= out_valid && (out_sum === v.sum) &&
                  (out_cout === v.cout) && !in_ready;
        cycle();
      end
      chk("bp_hold", (W+1)'(stable), (W+1)'(1));
      out_ready = 1'b1;
    end
    cycle();
    chk("idle_after_done", (W+1)'({in_ready, out_valid}), (W+1)'(2'b10));
  endtask

  vec_t vt[$];
  vec_t v1;
  vec_t v2;
  logic [W:0] r;
  int acc1;
  int acc2;
  int nacc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    pend_sum = '0; pend_cout = 1'b0;
    @(negedge clk);
    cycle();
    chk("rst_out_valid", (W+1)'(out_valid), '0);
    chk("rst_out", {out_cout, out_sum}, '0);
    chk("rst_cla", (W+1)'({cla_x, cla_y, cla_cin}), '0);
    rst = 1'b0;
    cycle();
    chk("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));

    vt.push_back(mk(128'h1, '1, 1'b0, 1'b0, '0, 1'b1));
    vt.push_back(mk('0, '0, 1'b1, 1'b0, 128'h1, 1'b0));
    vt.push_back(mk('1, '1, 1'b1, 1'b0, '1, 1'b1));
    vt.push_back(mk({1'b1, 127'h0}, {1'b1, 127'h0}, 1'b0, 1'b0, '0, 1'b1));
    vt.push_back(mk(128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF,
                    128'h0000_0000_0000_0001_0000_0000_0000_0001, 1'b0, 1'b0,
                    128'h0000_0001_0000_0000_0000_0001_0000_0000, 1'b0));
    for (int i = 0; i < 3; i++) begin
      v1.a = {$urandom, $urandom, $urandom, $urandom};
      v1.b = {$urandom, $urandom, $urandom, $urandom};
      v1.cin = 1'($urandom_range(1));
      r = {1'b0, v1.a} + {1'b0, v1.b} + (W+1)'(v1.cin);
      vt.push_back(mk(v1.a, v1.b, v1.cin, 1'b0, r[W-1:0], r[W]));
    end
`ifdef WIDE_ADD_SUB_EN
    vt.push_back(mk(128'd5, 128'd7, 1'b0, 1'b1, {{127{1'b1}}, 1'b0}, 1'b0));
    vt.push_back(mk(128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1));
    vt.push_back(mk(128'd9, 128'd9, 1'b0, 1'b1, '0, 1'b1));
`endif
    foreach (vt[i]) do_op(vt[i], 0);

    // Backpressure: carry out of slice 2 feeds slice 3.
    v1 = mk(128'h0000_0002_FFFF_FFFF_0000_0000_0000_0005,
            128'h0000_0002_FFFF_FFFF_0000_0000_0000_0005, 1'b0, 1'b0,
            128'h0000_0005_FFFF_FFFE_0000_0000_0000_000A, 1'b0);
    do_op(v1, 7);

    // Reset during the second RUN cycle.
    in_a = '1; in_b = 128'h1; in_cin = 1'b1; in_sub = 1'b0;
    pend_sum = '0; pend_cout = 1'b0;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    sb.delete();
    chk("abort_state", (W+1)'({in_ready, out_valid}), (W+1)'(2'b10));
    chk("abort_cla", (W+1)'({cla_x, cla_y, cla_cin}), '0);
    rst = 1'b0;
    do_op(mk('0, '0, 1'b0, 1'b0, '0, 1'b0), 0);
    do_op(mk(128'h3, 128'h4, 1'b0, 1'b0, 128'h7, 1'b0), 0);

    // Back-to-back with in_valid held high.
    v1 = mk(128'h10, 128'h20, 1'b0, 1'b0, 128'h30, 1'b0);
    v2 = mk({32'h1, 96'h0}, '1, 1'b1, 1'b0, {32'h1, 96'h0}, 1'b1);
    in_a = v1.a; in_b = v1.b; in_cin = v1.cin; in_sub = 1'b0;
    pend_sum = v1.sum; pend_cout = v1.cout;
    in_valid = 1'b1; out_ready = 1'b1;
    delivered = 0; nacc = 0; acc1 = 0; acc2 = 0;
    for (int i = 0; i < 40 && delivered < 2; i++) begin
      if (in_valid && in_ready) begin
        nacc++;
        if (nacc == 1) acc1 = edges;
        else acc2 = edges;
        cycle();
        if (nacc == 1) begin
          in_a = v2.a; in_b = v2.b; in_cin = v2.cin;
          pend_sum = v2.sum; pend_cout = v2.cout;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        cycle();
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", (W+1)'(nacc), (W+1)'(2));
    chk("b2b_results", (W+1)'(delivered), (W+1)'(2));
    chk("b2b_gap", (W+1)'(acc2 - acc1), (W+1)'(NW + 2));

    cycle();
    chk("sb_empty", (W+1)'(sb.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
